// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU (priority) and FIFO-buffered slow-path results into one registered regfile write.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_reg,
  input  logic [31:0] ld_data,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data_reg,
  output logic        regWrite,
  output logic [31:0] pending_mask
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]    fr [DEPTH];
  logic [31:0]   fd [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic [SW-1:0] starve;
  logic          drain, alu_win, pop, push;
  assign drain    = (starve == SW'(STARVE_LIMIT)) && (count != 0);
  assign alu_ready = !drain;
  assign ld_ready  = count != (AW+1)'(DEPTH);
  assign alu_win   = alu_valid && alu_ready;
  assign pop       = !alu_win && (count != 0);
  // r0 loads are acknowledged but never occupy a slot
  assign push      = ld_valid && ld_ready && (ld_reg != 5'd0);
  always_ff @(posedge clk)
    if (push) begin
      fr[wp] <= ld_reg;
      fd[wp] <= ld_data;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp             <= '0;
      rp             <= '0;
      count          <= '0;
      starve         <= '0;
      write_reg      <= '0;
      write_data_reg <= '0;
      regWrite       <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count    <= count + (AW+1)'(push) - (AW+1)'(pop);
      starve   <= (pop || count == 0) ? '0 :
                  (alu_win && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
      regWrite <= alu_win ? (alu_reg != 5'd0) : pop;
      if (alu_win || pop) begin
        write_reg      <= alu_win ? alu_reg : fr[rp];
        write_data_reg <= alu_win ? alu_data : fd[rp];
      end
    end
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((AW+1)'(i) < count) pending_mask[fr[rp + AW'(i)]] = 1'b1;
    pending_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenario tests for the writeback arbiter.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, ld_valid, ld_ready, regWrite;
  logic [4:0]  alu_reg, ld_reg, write_reg;
  logic [31:0] alu_data, ld_data, write_data_reg, pending_mask;
  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .write_reg(write_reg), .write_data_reg(write_data_reg), .regWrite(regWrite),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    ld_valid = 0; ld_reg = 0; ld_data = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick(); tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", regWrite); end
    checks++; if (write_reg !== 5'd0 || write_data_reg !== 32'd0) begin errors++; $display("FAIL reset_write got %0d/%h exp 0/0", write_reg, write_data_reg); end
    checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL reset_mask got %h exp 0", pending_mask); end
    checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b exp 11", ld_ready, alu_ready); end
    rst = 0;
    tick();
  endtask

  task automatic test_single();
    ld_valid = 1; ld_reg = 5; ld_data = 32'h1234;
    tick();
    ld_valid = 0;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL single_lat1 got regWrite %b exp 0", regWrite); end
    checks++; if (pending_mask !== 32'h20) begin errors++; $display("FAIL single_mask got %h exp 00000020", pending_mask); end
    tick();
    checks++; if (regWrite !== 1'b1 || write_reg !== 5'd5 || write_data_reg !== 32'h1234) begin errors++; $display("FAIL single_write got %b/%0d/%h exp 1/5/1234", regWrite, write_reg, write_data_reg); end
    checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL single_mask_clr got %h exp 0", pending_mask); end
    tick();
    checks++; if (regWrite !== 1'b0 || write_reg !== 5'd5 || write_data_reg !== 32'h1234) begin errors++; $display("FAIL single_hold got %b/%0d/%h exp 0/5/1234", regWrite, write_reg, write_data_reg); end
  endtask

  task automatic test_priority();
    alu_valid = 1; alu_reg = 3; alu_data = 7;
    ld_valid = 1; ld_reg = 4; ld_data = 9;
    tick();
    idle_inputs();
    checks++; if (regWrite !== 1'b1 || write_reg !== 5'd3 || write_data_reg !== 32'd7) begin errors++; $display("FAIL prio_alu got %b/%0d/%0d exp 1/3/7", regWrite, write_reg, write_data_reg); end
    checks++; if (pending_mask !== 32'h10) begin errors++; $display("FAIL prio_mask got %h exp 00000010", pending_mask); end
    tick();
    checks++; if (regWrite !== 1'b1 || write_reg !== 5'd4 || write_data_reg !== 32'd9) begin errors++; $display("FAIL prio_ld got %b/%0d/%0d exp 1/4/9", regWrite, write_reg, write_data_reg); end
    checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL prio_mask_clr got %h exp 0", pending_mask); end
    tick();
  endtask

  task automatic test_full();
    alu_valid = 1; alu_reg = 1;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'h500 + i;
      ld_valid = 1; ld_reg = 5'(10 + i); ld_data = 32'hA0 + i;
      tick();
      checks++; if (regWrite !== 1'b1 || write_reg !== 5'd1 || write_data_reg !== 32'h500 + i) begin errors++; $display("FAIL full_alu%0d got %b/%0d/%h", i, regWrite, write_reg, write_data_reg); end
    end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", ld_ready); end
    checks++; if (pending_mask !== 32'h3C00) begin errors++; $display("FAIL full_mask got %h exp 00003c00", pending_mask); end
    alu_valid = 0;
    ld_reg = 14; ld_data = 32'hA4;
    tick();
    checks++; if (write_reg !== 5'd10 || write_data_reg !== 32'hA0 || regWrite !== 1'b1) begin errors++; $display("FAIL full_pop0 got %0d/%h exp 10/a0", write_reg, write_data_reg); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %b exp 1", ld_ready); end
    tick();
    ld_valid = 0;
    checks++; if (write_reg !== 5'd11 || write_data_reg !== 32'hA1) begin errors++; $display("FAIL full_pop1 got %0d/%h exp 11/a1", write_reg, write_data_reg); end
    checks++; if (pending_mask !== 32'h7000) begin errors++; $display("FAIL full_mask2 got %h exp 00007000", pending_mask); end
    for (int i = 2; i < 5; i++) begin
      tick();
      checks++; if (regWrite !== 1'b1 || write_reg !== 5'(10 + i) || write_data_reg !== 32'hA0 + i) begin errors++; $display("FAIL full_pop%0d got %b/%0d/%h", i, regWrite, write_reg, write_data_reg); end
    end
    tick();
    checks++; if (regWrite !== 1'b0 || pending_mask !== 32'd0) begin errors++; $display("FAIL full_drained got %b/%h exp 0/0", regWrite, pending_mask); end
  endtask

  task automatic test_starve();
    alu_valid = 1; alu_reg = 2; alu_data = 100;
    ld_valid = 1; ld_reg = 20; ld_data = 55;
    tick();
    ld_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL starve_ready%0d got %b exp 1", k, alu_ready); end
      alu_data = 100 + k;
      tick();
      checks++; if (write_reg !== 5'd2 || write_data_reg !== 32'(100 + k)) begin errors++; $display("FAIL starve_win%0d got %0d/%0d exp 2/%0d", k, write_reg, write_data_reg, 100 + k); end
    end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL starve_force got %b exp 0", alu_ready); end
    tick();
    checks++; if (regWrite !== 1'b1 || write_reg !== 5'd20 || write_data_reg !== 32'd55) begin errors++; $display("FAIL starve_drain got %b/%0d/%0d exp 1/20/55", regWrite, write_reg, write_data_reg); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL starve_release got %b exp 1", alu_ready); end
    tick();
    checks++; if (write_reg !== 5'd2 || write_data_reg !== 32'd108) begin errors++; $display("FAIL starve_resume got %0d/%0d exp 2/108", write_reg, write_data_reg); end
    idle_inputs();
    tick();
  endtask

  task automatic test_r0();
    alu_valid = 1; alu_reg = 0; alu_data = 99;
    tick();
    alu_valid = 0;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL r0_alu got regWrite %b exp 0", regWrite); end
    ld_valid = 1; ld_reg = 0; ld_data = 77;
    tick();
    ld_valid = 0;
    checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL r0_ld_mask got %h exp 0", pending_mask); end
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL r0_ld_write got regWrite %b exp 0", regWrite); end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_reg = 1; alu_data = 1;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_reg = 5'(7 + i); ld_data = 32'(i);
      tick();
    end
    idle_inputs();
    alu_valid = 1; alu_reg = 1;
    checks++; if (pending_mask !== 32'h380 || regWrite !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %h/%b exp 00000380/1", pending_mask, regWrite); end
    #2 rst = 1;
    #1;
    checks++; if (regWrite !== 1'b0 || pending_mask !== 32'd0) begin errors++; $display("FAIL rstmid_now got %b/%h exp 0/0", regWrite, pending_mask); end
    idle_inputs();
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL rstmid_after%0d got regWrite %b exp 0", i, regWrite); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_full();
    test_starve();
    test_r0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
